fetch_unit: RTL and testbench

//  IF stage of the 16-bit pipelined datapath: owns the PC, drives instruction memory through a

---
 rtl/fetch_unit_pkg.sv | 24 ++
 rtl/fetch_btb.sv | 71 +++++++
 rtl/fetch_unit.sv | 197 +++++++++++++++++++
 tb/tb_fetch_unit.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit_pkg
// Purpose  : Shared fetch-stage encodings: FSM states, bubble word, BTB counters.
// Revision : 1.0
// ============================================================================
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DROP  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [15:0] BUBBLE_INST = 16'h0000;

  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/fetch_btb.sv
`default_nettype none
// ============================================================================
// Module   : fetch_btb
// Purpose  : Direct-mapped branch target buffer with 2-bit counters.
// Revision : 1.0
// ============================================================================
module fetch_btb
  import fetch_unit_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int IDX_BITS  = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WORD_SIZE-1:0] lookup_pc,
  output logic                 pred_taken,
  output logic [WORD_SIZE-1:0] pred_target,
  input  logic                 upd_en,
  input  logic [WORD_SIZE-1:0] upd_pc,
  input  logic                 upd_taken,
  input  logic [WORD_SIZE-1:0] upd_target
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = WORD_SIZE - IDX_BITS;

  logic [ENTRIES-1:0]   r_valid;
  logic [TAG_W-1:0]     r_tag    [ENTRIES];
  logic [WORD_SIZE-1:0] r_target [ENTRIES];
  logic [1:0]           r_ctr    [ENTRIES];

  logic [IDX_BITS-1:0] w_l_idx;
  logic [IDX_BITS-1:0] w_u_idx;
  logic                w_l_hit;
  logic                w_u_hit;

  assign w_l_idx     = lookup_pc[IDX_BITS-1:0];
  assign w_u_idx     = upd_pc[IDX_BITS-1:0];
  assign w_l_hit     = r_valid[w_l_idx] && (r_tag[w_l_idx] == lookup_pc[WORD_SIZE-1:IDX_BITS]);
  assign w_u_hit     = r_valid[w_u_idx] && (r_tag[w_u_idx] == upd_pc[WORD_SIZE-1:IDX_BITS]);
  assign pred_taken  = w_l_hit && r_ctr[w_l_idx][1];
  assign pred_target = r_target[w_l_idx];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= '0;
    end else if (upd_en && !w_u_hit && upd_taken) begin
      r_valid[w_u_idx] <= 1'b1;
    end
  end

  // Payload storage needs no reset: entries are ignored until their valid bit is set.
  always_ff @(posedge clk) begin
    if (upd_en) begin
      if (w_u_hit) begin
        r_target[w_u_idx] <= upd_target;
        if (upd_taken && r_ctr[w_u_idx] != ST) begin
          r_ctr[w_u_idx] <= r_ctr[w_u_idx] + 2'd1;
        end else if (!upd_taken && r_ctr[w_u_idx] != SNT) begin
          r_ctr[w_u_idx] <= r_ctr[w_u_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        r_tag[w_u_idx]    <= upd_pc[WORD_SIZE-1:IDX_BITS];
        r_target[w_u_idx] <= upd_target;
        r_ctr[w_u_idx]    <= WT;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : IF stage: PC, imem read/ready handshake, IF/ID latch, stall/flush/halt.
//            Define FETCH_BTB_EN to enable BTB-based next-PC prediction.
// Revision : 1.0
// ============================================================================
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                   WORD_SIZE    = 16,
  parameter logic [WORD_SIZE-1:0] RESET_PC     = '0,
  parameter int                   BTB_IDX_BITS = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  output logic                 imem_read,
  output logic [WORD_SIZE-1:0] imem_addr,
  input  logic [WORD_SIZE-1:0] imem_data,
  input  logic                 imem_ready,
  input  logic                 stall,
  input  logic                 flush,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  input  logic                 halt,
  input  logic                 ex_update,
  input  logic [WORD_SIZE-1:0] ex_pc,
  input  logic                 ex_taken,
  input  logic [WORD_SIZE-1:0] ex_target,
  output logic                 if_valid,
  output logic [WORD_SIZE-1:0] if_inst,
  output logic [WORD_SIZE-1:0] if_pc,
  output logic [WORD_SIZE-1:0] if_pred_pc,
  output logic [15:0]          num_fetched
);

  localparam logic [WORD_SIZE-1:0] BUBBLE = WORD_SIZE'(BUBBLE_INST);

  state_t               r_state, w_state;
  logic                 r_run;
  logic [WORD_SIZE-1:0] r_pc, w_pc, r_drop_addr, w_drop_addr;
  logic [WORD_SIZE-1:0] r_h_inst, w_h_inst, r_h_pc, w_h_pc, r_h_pred, w_h_pred;
  logic                 r_valid, w_valid;
  logic [WORD_SIZE-1:0] r_inst, w_inst, r_if_pc, w_if_pc, r_pred, w_pred;
  logic [15:0]          r_num, w_num;
  logic [WORD_SIZE-1:0] w_next_pc;
  logic                 w_read, w_ready;
  logic [WORD_SIZE-1:0] w_addr;

`ifdef FETCH_BTB_EN
  logic                 w_btb_taken;
  logic [WORD_SIZE-1:0] w_btb_target;

  fetch_btb #(
    .WORD_SIZE (WORD_SIZE),
    .IDX_BITS  (BTB_IDX_BITS)
  ) u_btb (
    .clk         (clk),
    .reset_n     (reset_n),
    .lookup_pc   (r_pc),
    .pred_taken  (w_btb_taken),
    .pred_target (w_btb_target),
    .upd_en      (ex_update),
    .upd_pc      (ex_pc),
    .upd_taken   (ex_taken),
    .upd_target  (ex_target)
  );

  assign w_next_pc = w_btb_taken ? w_btb_target : r_pc + WORD_SIZE'(1);
`else
  logic w_unused_ex;
  assign w_unused_ex = ^{ex_update, ex_pc, ex_taken, ex_target, (BTB_IDX_BITS > 0)};
  assign w_next_pc   = r_pc + WORD_SIZE'(1);
`endif

  // The request is held back for one cycle after reset release.
  assign w_read  = r_run && (r_state == S_FETCH || r_state == S_DROP);
  assign w_addr  = (r_state == S_DROP) ? r_drop_addr : r_pc;
  assign w_ready = imem_ready && w_read;

  assign imem_read   = w_read;
  assign imem_addr   = w_addr;
  assign if_valid    = r_valid;
  assign if_inst     = r_inst;
  assign if_pc       = r_if_pc;
  assign if_pred_pc  = r_pred;
  assign num_fetched = r_num;

  always_comb begin
    w_state     = r_state;
    w_pc        = r_pc;
    w_drop_addr = r_drop_addr;
    w_h_inst    = r_h_inst;
    w_h_pc      = r_h_pc;
    w_h_pred    = r_h_pred;
    w_valid     = r_valid;
    w_inst      = r_inst;
    w_if_pc     = r_if_pc;
    w_pred      = r_pred;
    w_num       = r_num;
    if (flush) begin
      w_pc     = redirect_pc;
      w_valid  = 1'b0;
      w_inst   = BUBBLE;
      w_h_inst = '0;
      w_h_pc   = '0;
      w_h_pred = '0;
      // A read still in flight must be drained before the new address is issued.
      if (w_read && !imem_ready) begin
        w_state     = S_DROP;
        w_drop_addr = w_addr;
      end else begin
        w_state = S_FETCH;
      end
    end else if (halt) begin
      w_state  = S_HALT;
      w_valid  = 1'b0;
      w_inst   = BUBBLE;
      w_h_inst = '0;
      w_h_pc   = '0;
      w_h_pred = '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (w_ready) begin
            w_pc = w_next_pc;
            if (stall) begin
              w_h_inst = imem_data;
              w_h_pc   = r_pc;
              w_h_pred = w_next_pc;
              w_state  = S_HOLD;
            end else begin
              w_valid = 1'b1;
              w_inst  = imem_data;
              w_if_pc = r_pc;
              w_pred  = w_next_pc;
              w_num   = r_num + 16'd1;
            end
          end else if (!stall) begin
            w_valid = 1'b0;
            w_inst  = BUBBLE;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            w_valid = 1'b1;
            w_inst  = r_h_inst;
            w_if_pc = r_h_pc;
            w_pred  = r_h_pred;
            w_num   = r_num + 16'd1;
            w_state = S_FETCH;
          end
        end
        S_DROP: begin
          w_valid = 1'b0;
          w_inst  = BUBBLE;
          if (w_ready) w_state = S_FETCH;
        end
        default: begin
          w_valid = 1'b0;
          w_inst  = BUBBLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_FETCH;
      r_run       <= 1'b0;
      r_pc        <= RESET_PC;
      r_drop_addr <= '0;
      r_h_inst    <= '0;
      r_h_pc      <= '0;
      r_h_pred    <= '0;
      r_valid     <= 1'b0;
      r_inst      <= BUBBLE;
      r_if_pc     <= '0;
      r_pred      <= '0;
      r_num       <= '0;
    end else begin
      r_state     <= w_state;
      r_run       <= 1'b1;
      r_pc        <= w_pc;
      r_drop_addr <= w_drop_addr;
      r_h_inst    <= w_h_inst;
      r_h_pc      <= w_h_pc;
      r_h_pred    <= w_h_pred;
      r_valid     <= w_valid;
      r_inst      <= w_inst;
      r_if_pc     <= w_if_pc;
      r_pred      <= w_pred;
      r_num       <= w_num;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Directed self-checking bench for fetch_unit with a variable-latency imem.
// Revision : 1.0
// ============================================================================
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_read;
  logic [15:0] imem_addr;
  logic [15:0] imem_data = 16'h0;
  logic        imem_ready = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] redirect_pc = 16'h0;
  logic        halt = 1'b0;
  logic        ex_update = 1'b0;
  logic [15:0] ex_pc = 16'h0;
  logic        ex_taken = 1'b0;
  logic [15:0] ex_target = 16'h0;
  logic        if_valid;
  logic [15:0] if_inst;
  logic [15:0] if_pc;
  logic [15:0] if_pred_pc;
  logic [15:0] num_fetched;

  int n_tests = 0;
  int n_fail  = 0;
  int mem_lat = 1;
  int mem_cnt = 0;

  fetch_unit dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .imem_read   (imem_read),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .imem_ready  (imem_ready),
    .stall       (stall),
    .flush       (flush),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .ex_update   (ex_update),
    .ex_pc       (ex_pc),
    .ex_taken    (ex_taken),
    .ex_target   (ex_target),
    .if_valid    (if_valid),
    .if_inst     (if_inst),
    .if_pc       (if_pc),
    .if_pred_pc  (if_pred_pc),
    .num_fetched (num_fetched)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'hBEEF;
  endfunction

  // Memory answers in the mem_lat-th cycle a request is presented; dropping read aborts it.
  always @(negedge clk) begin
    if (!imem_read) begin
      imem_ready = 1'b0;
      mem_cnt    = 0;
    end else begin
      mem_cnt = mem_cnt + 1;
      if (mem_cnt >= mem_lat) begin
        imem_ready = 1'b1;
        imem_data  = mem_word(imem_addr);
        mem_cnt    = 0;
      end else begin
        imem_ready = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    stall = 1'b0; flush = 1'b0; halt = 1'b0; ex_update = 1'b0; mem_lat = 1;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic wait_addr(input logic [15:0] a);
    bit ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      tick();
      if (imem_read && imem_addr == a) ok = 1'b1;
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL wait_addr: timeout, last addr %h read %b, required addr %h", imem_addr, imem_read, a);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    n_tests++;
    if ({imem_read, if_valid, if_inst, if_pc, if_pred_pc, num_fetched} !== 66'h0) begin
      n_fail++;
      $display("FAIL reset_state: read=%b valid=%b inst=%h pc=%h pred=%h num=%0d, required all zero",
               imem_read, if_valid, if_inst, if_pc, if_pred_pc, num_fetched);
    end
    reset_n = 1'b1;
    tick();
    n_tests++;
    if ({imem_read, imem_addr, if_valid} !== {1'b1, 16'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL first_req: read=%b addr=%h valid=%b, required 1/0000/0", imem_read, imem_addr, if_valid);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if ({if_valid, if_pc, if_inst, if_pred_pc} !== {1'b1, 16'(i), mem_word(16'(i)), 16'(i + 1)}) begin
        n_fail++;
        $display("FAIL seq_fetch%0d: valid=%b pc=%h inst=%h pred=%h, required 1/%h/%h/%h", i,
                 if_valid, if_pc, if_inst, if_pred_pc, 16'(i), mem_word(16'(i)), 16'(i + 1));
      end
    end
    n_tests++;
    if (num_fetched !== 16'd3) begin
      n_fail++;
      $display("FAIL seq_count: num_fetched=%0d, required 3", num_fetched);
    end
  endtask

  task automatic test_latency();
    do_reset();
    wait_addr(16'h5);
    mem_lat = 3;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_tests++;
      if ({imem_read, imem_addr, if_valid} !== {1'b1, 16'h5, 1'b0}) begin
        n_fail++;
        $display("FAIL lat_wait%0d: read=%b addr=%h valid=%b, required 1/0005/0", i, imem_read, imem_addr, if_valid);
      end
    end
    tick();
    n_tests++;
    if ({if_valid, if_pc, if_inst} !== {1'b1, 16'h5, mem_word(16'h5)}) begin
      n_fail++;
      $display("FAIL lat_data: valid=%b pc=%h inst=%h, required 1/0005/%h", if_valid, if_pc, if_inst, mem_word(16'h5));
    end
  endtask

  task automatic test_stall();
    do_reset();
    wait_addr(16'h7);
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_tests++;
      if ({if_valid, if_pc, if_inst, imem_read, num_fetched} !== {1'b1, 16'h6, mem_word(16'h6), 1'b0, 16'd7}) begin
        n_fail++;
        $display("FAIL stall_hold%0d: valid=%b pc=%h inst=%h read=%b num=%0d, required 1/0006/%h/0/7", i,
                 if_valid, if_pc, if_inst, imem_read, num_fetched, mem_word(16'h6));
      end
    end
    stall = 1'b0;
    tick();
    n_tests++;
    if ({if_valid, if_pc, if_inst, if_pred_pc, num_fetched} !== {1'b1, 16'h7, mem_word(16'h7), 16'h8, 16'd8}) begin
      n_fail++;
      $display("FAIL stall_release: valid=%b pc=%h inst=%h pred=%h num=%0d, required 1/0007/%h/0008/8",
               if_valid, if_pc, if_inst, if_pred_pc, num_fetched, mem_word(16'h7));
    end
    tick();
    n_tests++;
    if ({if_valid, if_pc, num_fetched} !== {1'b1, 16'h8, 16'd9}) begin
      n_fail++;
      $display("FAIL stall_next: valid=%b pc=%h num=%0d, required 1/0008/9", if_valid, if_pc, num_fetched);
    end
  endtask

  task automatic test_flush();
    do_reset();
    wait_addr(16'h10);
    mem_lat = 3;
    tick();
    flush = 1'b1;
    redirect_pc = 16'h40;
    tick();
    flush = 1'b0;
    n_tests++;
    if ({imem_read, imem_addr, if_valid} !== {1'b1, 16'h10, 1'b0}) begin
      n_fail++;
      $display("FAIL flush_drop: read=%b addr=%h valid=%b, required 1/0010/0", imem_read, imem_addr, if_valid);
    end
    tick();
    mem_lat = 1;
    n_tests++;
    if ({imem_read, imem_addr, if_valid} !== {1'b1, 16'h40, 1'b0}) begin
      n_fail++;
      $display("FAIL flush_discard: read=%b addr=%h valid=%b, required 1/0040/0", imem_read, imem_addr, if_valid);
    end
    tick();
    n_tests++;
    if ({if_valid, if_pc, if_inst, num_fetched} !== {1'b1, 16'h40, mem_word(16'h40), 16'd17}) begin
      n_fail++;
      $display("FAIL flush_resume: valid=%b pc=%h inst=%h num=%0d, required 1/0040/%h/17",
               if_valid, if_pc, if_inst, num_fetched, mem_word(16'h40));
    end
  endtask

  task automatic test_halt();
    do_reset();
    wait_addr(16'h20);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    n_tests++;
    if ({imem_read, if_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL halt_enter: read=%b valid=%b, required 0/0", imem_read, if_valid);
    end
    tick();
    tick();
    n_tests++;
    if ({imem_read, if_valid, num_fetched} !== {2'b00, 16'd32}) begin
      n_fail++;
      $display("FAIL halt_stay: read=%b valid=%b num=%0d, required 0/0/32", imem_read, if_valid, num_fetched);
    end
    flush = 1'b1;
    redirect_pc = 16'h30;
    tick();
    flush = 1'b0;
    n_tests++;
    if ({imem_read, imem_addr, if_valid} !== {1'b1, 16'h30, 1'b0}) begin
      n_fail++;
      $display("FAIL halt_exit: read=%b addr=%h valid=%b, required 1/0030/0", imem_read, imem_addr, if_valid);
    end
    tick();
    n_tests++;
    if ({if_valid, if_pc, if_inst} !== {1'b1, 16'h30, mem_word(16'h30)}) begin
      n_fail++;
      $display("FAIL halt_resume: valid=%b pc=%h inst=%h, required 1/0030/%h", if_valid, if_pc, if_inst, mem_word(16'h30));
    end
  endtask

  task automatic test_btb();
    logic [15:0] exp_next;
`ifdef FETCH_BTB_EN
    exp_next = 16'h50;
`else
    exp_next = 16'h5;
`endif
    do_reset();
    ex_update = 1'b1;
    ex_pc     = 16'h4;
    ex_taken  = 1'b1;
    ex_target = 16'h50;
    tick();
    tick();
    ex_update = 1'b0;
    wait_addr(16'h4);
    tick();
    n_tests++;
    if ({if_valid, if_pc, if_pred_pc, imem_addr} !== {1'b1, 16'h4, exp_next, exp_next}) begin
      n_fail++;
      $display("FAIL btb_predict: valid=%b pc=%h pred=%h addr=%h, required 1/0004/%h/%h",
               if_valid, if_pc, if_pred_pc, imem_addr, exp_next, exp_next);
    end
    tick();
    n_tests++;
    if ({if_valid, if_pc, if_inst} !== {1'b1, exp_next, mem_word(exp_next)}) begin
      n_fail++;
      $display("FAIL btb_follow: valid=%b pc=%h inst=%h, required 1/%h/%h", if_valid, if_pc, if_inst, exp_next, mem_word(exp_next));
    end
  endtask

  task automatic test_reset_in_drop();
    do_reset();
    wait_addr(16'h3);
    mem_lat = 4;
    tick();
    flush = 1'b1;
    redirect_pc = 16'h40;
    tick();
    flush = 1'b0;
    n_tests++;
    if ({imem_read, imem_addr} !== {1'b1, 16'h3}) begin
      n_fail++;
      $display("FAIL drop_entry: read=%b addr=%h, required 1/0003", imem_read, imem_addr);
    end
    #2 reset_n = 1'b0;
    #1;
    n_tests++;
    if ({imem_read, imem_addr, if_valid, if_inst, if_pc, if_pred_pc, num_fetched} !== 82'h0) begin
      n_fail++;
      $display("FAIL async_reset: read=%b addr=%h valid=%b inst=%h pc=%h pred=%h num=%0d, required all zero",
               imem_read, imem_addr, if_valid, if_inst, if_pc, if_pred_pc, num_fetched);
    end
    mem_lat = 1;
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    n_tests++;
    if ({if_valid, if_pc, if_inst, num_fetched} !== {1'b1, 16'h0, mem_word(16'h0), 16'd1}) begin
      n_fail++;
      $display("FAIL refetch: valid=%b pc=%h inst=%h num=%0d, required 1/0000/%h/1",
               if_valid, if_pc, if_inst, num_fetched, mem_word(16'h0));
    end
  endtask

  task automatic test_wrap();
    do_reset();
    tick();
    flush = 1'b1;
    redirect_pc = 16'hFFFF;
    tick();
    flush = 1'b0;
    n_tests++;
    if ({imem_read, imem_addr, if_valid} !== {1'b1, 16'hFFFF, 1'b0}) begin
      n_fail++;
      $display("FAIL wrap_redirect: read=%b addr=%h valid=%b, required 1/ffff/0", imem_read, imem_addr, if_valid);
    end
    tick();
    n_tests++;
    if ({if_valid, if_pc, if_pred_pc} !== {1'b1, 16'hFFFF, 16'h0}) begin
      n_fail++;
      $display("FAIL wrap_pred: valid=%b pc=%h pred=%h, required 1/ffff/0000", if_valid, if_pc, if_pred_pc);
    end
    tick();
    n_tests++;
    if ({if_valid, if_pc, num_fetched} !== {1'b1, 16'h0, 16'd2}) begin
      n_fail++;
      $display("FAIL wrap_next: valid=%b pc=%h num=%0d, required 1/0000/2", if_valid, if_pc, num_fetched);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_stall();
    test_flush();
    test_halt();
    test_btb();
    test_reset_in_drop();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
